// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered RV32I(M) decoder producing the ID/EX
// control word, with bubble/flush/stall handling and a multi-cycle
// sequencer for M-extension ops.
// Build option: define M_EXT_EN to decode MUL/DIV ops and build the
// WAIT-state sequencer; without it funct7 0000001 decodes as illegal.
//
// state  | meaning
// S_IDLE | accepting a new instruction each cycle (or bubbling)
// S_WAIT | multi-cycle M op in EX; word held, BUSY high, counter running
module pipelined_control_unit #(
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 32,
  parameter int ALUOP_WIDTH = 5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            INSTRUCTION,
  input  logic                   INSTR_VALID,
  input  logic                   STALL_IN,
  input  logic                   FLUSH,
  output logic                   MUX1,
  output logic                   MUX2,
  output logic                   MUX3,
  output logic                   REGISTERWRITE,
  output logic                   MEMORYWRITE,
  output logic                   MEMORYREAD,
  output logic                   BRANCH,
  output logic                   JUMP,
  output logic                   JAL,
  output logic                   TWOSCOMP,
  output logic [ALUOP_WIDTH-1:0] ALUOP,
  output logic [2:0]             IMMEDIATE,
  output logic                   CTRL_VALID,
  output logic                   BUSY,
  output logic                   ILLEGAL
);

  localparam int CW = 10 + ALUOP_WIDTH + 3;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_IALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_SLL = 2, OP_SLT = 3, OP_SLTU = 4;
  localparam int OP_XOR = 5, OP_SRL = 6, OP_SRA = 7, OP_OR = 8, OP_AND = 9;
  localparam int OP_MUL = 10, OP_FWD = 18;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011, IMM_J = 3'b100;

  // Parameter sanity check at elaboration time.
  if (MUL_LATENCY < 1 || MUL_LATENCY > 63 || DIV_LATENCY < 1 || DIV_LATENCY > 63 ||
      ALUOP_WIDTH < 5) begin : g_param_check
    $error("pipelined_control_unit: latencies must be 1..63 and ALUOP_WIDTH >= 5");
  end

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = INSTRUCTION[6:0];
  assign funct3 = INSTRUCTION[14:12];
  assign funct7 = INSTRUCTION[31:25];

  // Register/immediate fields are consumed downstream, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

  logic d_mux1, d_mux2, d_mux3, d_regwr, d_memwr, d_memrd;
  logic d_branch, d_jump, d_jal, d_twos, d_illegal;
  logic [ALUOP_WIDTH-1:0] d_aluop;
  logic [2:0] d_imm;
  logic [CW-1:0] dec_word;
`ifdef M_EXT_EN
  logic d_mop;
  logic [5:0] d_lat;
`endif

  // Combinational decode of the presented instruction.
  always_comb begin
    d_mux1 = 1'b0; d_mux2 = 1'b0; d_mux3 = 1'b0; d_regwr = 1'b0;
    d_memwr = 1'b0; d_memrd = 1'b0; d_branch = 1'b0; d_jump = 1'b0;
    d_jal = 1'b0; d_twos = 1'b0; d_illegal = 1'b0;
    d_aluop = ALUOP_WIDTH'(OP_ADD);
    d_imm = IMM_I;
`ifdef M_EXT_EN
    d_mop = 1'b0;
    d_lat = funct3[2] ? 6'(DIV_LATENCY) : 6'(MUL_LATENCY);
`endif
    case (opcode)
      OPC_R: begin
        d_regwr = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'd0: d_aluop = ALUOP_WIDTH'(OP_ADD);
              3'd1: d_aluop = ALUOP_WIDTH'(OP_SLL);
              3'd2: d_aluop = ALUOP_WIDTH'(OP_SLT);
              3'd3: d_aluop = ALUOP_WIDTH'(OP_SLTU);
              3'd4: d_aluop = ALUOP_WIDTH'(OP_XOR);
              3'd5: d_aluop = ALUOP_WIDTH'(OP_SRL);
              3'd6: d_aluop = ALUOP_WIDTH'(OP_OR);
              default: d_aluop = ALUOP_WIDTH'(OP_AND);
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'd0) begin
              d_aluop = ALUOP_WIDTH'(OP_SUB);
              d_twos = 1'b1;
            end else if (funct3 == 3'd5) begin
              d_aluop = ALUOP_WIDTH'(OP_SRA);
            end else begin
              d_illegal = 1'b1;
            end
          end
`ifdef M_EXT_EN
          7'b0000001: begin
            d_aluop = ALUOP_WIDTH'(OP_MUL + int'(funct3));
            d_mop = 1'b1;
          end
`endif
          default: d_illegal = 1'b1;
        endcase
      end
      OPC_IALU: begin
        d_regwr = 1'b1;
        d_mux1 = 1'b1;
        case (funct3)
          3'd0: d_aluop = ALUOP_WIDTH'(OP_ADD);
          3'd2: d_aluop = ALUOP_WIDTH'(OP_SLT);
          3'd3: d_aluop = ALUOP_WIDTH'(OP_SLTU);
          3'd4: d_aluop = ALUOP_WIDTH'(OP_XOR);
          3'd6: d_aluop = ALUOP_WIDTH'(OP_OR);
          3'd7: d_aluop = ALUOP_WIDTH'(OP_AND);
          3'd1: begin
            d_aluop = ALUOP_WIDTH'(OP_SLL);
            d_illegal = (funct7 != 7'b0000000);
          end
          default: begin
            if (funct7 == 7'b0000000) d_aluop = ALUOP_WIDTH'(OP_SRL);
            else if (funct7 == 7'b0100000) d_aluop = ALUOP_WIDTH'(OP_SRA);
            else d_illegal = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        d_regwr = 1'b1; d_memrd = 1'b1; d_mux1 = 1'b1; d_mux3 = 1'b1;
        d_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        d_memwr = 1'b1; d_mux1 = 1'b1; d_imm = IMM_S;
        d_illegal = (funct3 > 3'd2);
      end
      OPC_BR: begin
        d_branch = 1'b1; d_twos = 1'b1; d_imm = IMM_B;
        d_aluop = ALUOP_WIDTH'(OP_SUB);
        d_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_JAL: begin
        d_jump = 1'b1; d_jal = 1'b1; d_regwr = 1'b1;
        d_mux1 = 1'b1; d_mux2 = 1'b1; d_imm = IMM_J;
      end
      OPC_JALR: begin
        d_jump = 1'b1; d_regwr = 1'b1; d_mux1 = 1'b1;
        d_illegal = (funct3 != 3'd0);
      end
      OPC_LUI: begin
        d_regwr = 1'b1; d_mux1 = 1'b1; d_imm = IMM_U;
        d_aluop = ALUOP_WIDTH'(OP_FWD);
      end
      OPC_AUIPC: begin
        d_regwr = 1'b1; d_mux1 = 1'b1; d_mux2 = 1'b1; d_imm = IMM_U;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign dec_word = {d_mux1, d_mux2, d_mux3, d_regwr, d_memwr, d_memrd,
                     d_branch, d_jump, d_jal, d_twos, d_aluop, d_imm};

  logic [CW-1:0] ctrl_q, ctrl_d;
  logic valid_q, valid_d, illegal_q, illegal_d;
  logic busy;

`ifdef M_EXT_EN
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  assign busy = (state_q == S_WAIT);
`else
  assign busy = 1'b0;
`endif

  // Next-state: flush beats busy-hold beats stall-hold beats accept/bubble.
  always_comb begin
    ctrl_d = ctrl_q;
    valid_d = valid_q;
    illegal_d = 1'b0;
`ifdef M_EXT_EN
    state_d = state_q;
    cnt_d = cnt_q;
`endif
    if (FLUSH) begin
      ctrl_d = '0;
      valid_d = 1'b0;
`ifdef M_EXT_EN
      state_d = S_IDLE;
      cnt_d = '0;
`endif
    end else if (busy) begin
`ifdef M_EXT_EN
      // Count runs even under STALL_IN so the EX unit latency stays fixed.
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        state_d = S_IDLE;
        cnt_d = '0;
      end
`endif
    end else if (STALL_IN) begin
      ctrl_d = ctrl_q;
    end else if (INSTR_VALID && !d_illegal) begin
      ctrl_d = dec_word;
      valid_d = 1'b1;
`ifdef M_EXT_EN
      if (d_mop && (d_lat > 6'd1)) begin
        state_d = S_WAIT;
        cnt_d = d_lat - 6'd1;
      end
`endif
    end else begin
      ctrl_d = '0;
      valid_d = 1'b0;
      illegal_d = INSTR_VALID;
    end
  end

  // Control-word, pulse and sequencer registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q <= '0;
      valid_q <= 1'b0;
      illegal_q <= 1'b0;
`ifdef M_EXT_EN
      state_q <= S_IDLE;
      cnt_q <= '0;
`endif
    end else begin
      ctrl_q <= ctrl_d;
      valid_q <= valid_d;
      illegal_q <= illegal_d;
`ifdef M_EXT_EN
      state_q <= state_d;
      cnt_q <= cnt_d;
`endif
    end
  end

  assign {MUX1, MUX2, MUX3, REGISTERWRITE, MEMORYWRITE, MEMORYREAD,
          BRANCH, JUMP, JAL, TWOSCOMP, ALUOP, IMMEDIATE} = ctrl_q;
  assign CTRL_VALID = valid_q;
  assign ILLEGAL = illegal_q;
  assign BUSY = busy;

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered, parametrised successor to the combinational RV32IM decoder. Decodes one instruction per cycle into the ID/EX control word.
- Sequences multi-cycle M-extension operations: holds the control word and back-pressures fetch/decode (BUSY) for a parametrised latency.
- Sits between the IF/ID register and the EX stage. Also handles pipeline flush, external hazard stall, bubbles and illegal opcodes.

Parameters:
- MUL_LATENCY, 1, EX cycles for MUL/MULH/MULHSU/MULHU (1..63).
- DIV_LATENCY, 32, EX cycles for DIV/DIVU/REM/REMU (1..63).
- ALUOP_WIDTH, 5, width of ALUOP (>=5).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- INSTRUCTION  in  32  instruction from IF/ID.
- INSTR_VALID  in  1  INSTRUCTION is valid this cycle.
- STALL_IN  in  1  hazard-unit stall; hold the current outputs.
- FLUSH  in  1  branch/jump taken; kill the current and in-flight word.
- MUX1  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- MUX2  out  1  ALU operand A: 0 = rs1, 1 = PC.
- MUX3  out  1  writeback source: 0 = ALU, 1 = memory.
- REGISTERWRITE, MEMORYWRITE, MEMORYREAD, BRANCH, JUMP, JAL, TWOSCOMP  out  1 each  control flags.
- ALUOP  out  ALUOP_WIDTH  ALU operation code.
- IMMEDIATE  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J.
- CTRL_VALID  out  1  control word is valid for EX.
- BUSY  out  1  multi-cycle operation in progress; upstream must hold.
- ILLEGAL  out  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- Reset: every output 0, FSM = IDLE, counter = 0. RESET overrides all other inputs, including mid multi-cycle operation.
- Update priority each edge: RESET > FLUSH > BUSY hold > STALL_IN hold > accept/bubble.
- ACCEPT = INSTR_VALID & ~BUSY & ~STALL_IN & ~FLUSH.
  - On ACCEPT: the decoded word is registered with CTRL_VALID = 1. Latency is 1 cycle (edge after presentation).
  - Not ACCEPT, and not stall/busy: bubble (all control outputs 0, CTRL_VALID = 0).
- FLUSH: next edge produces a bubble, FSM -> IDLE, counter cleared, BUSY = 0. The word presented alongside FLUSH is discarded.
- ALUOP encoding:
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9
  - MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17
  - FWD (pass immediate) 18
- Decode by opcode:
  - 0110011 R: REGWR = 1. funct7 0000000 -> base op; 0100000 -> SUB/SRA; 0000001 -> M op.
  - 0010011 I-ALU: REGWR, MUX1 = 1, IMM = I.
  - 0000011 load: REGWR, MEMRD, MUX1, MUX3, IMM = I, ADD.
  - 0100011 store: MEMWR, MUX1, IMM = S, ADD.
  - 1100011 branch: BRANCH, TWOSCOMP, IMM = B, SUB.
  - 1101111 JAL: JUMP, JAL, REGWR, MUX2, MUX1, IMM = J, ADD.
  - 1100111 JALR: JUMP, REGWR, MUX1, IMM = I, ADD.
  - 0110111 LUI: REGWR, MUX1, IMM = U, FWD.
  - 0010111 AUIPC: REGWR, MUX1, MUX2, IMM = U, ADD.
- TWOSCOMP = 1 for SUB and for branches.
- Illegal (any other opcode/funct7, or an invalid funct3 for the format): bubble, ILLEGAL = 1 for exactly one cycle, no FSM change.
- FSM:
  - IDLE -> WAIT on accepting an M op with LAT > 1; counter = LAT - 1.
  - In WAIT: BUSY = 1, the control word is held with CTRL_VALID = 1, and the counter decrements each cycle. STALL_IN does not pause the count.
  - WAIT -> IDLE when counter = 1 at an edge. BUSY is therefore high for exactly LAT - 1 cycles after the issue edge.
  - LAT = 1: no WAIT state, behaves like a base op.
- INSTR_VALID while BUSY is ignored; upstream must re-present the instruction.

Optional Feature:
- Macro M_EXT_EN.
- Defined: M ops decode as above and the FSM is present.
- Undefined: funct7 0000001 is illegal (ILLEGAL pulse, bubble), BUSY is tied 0, and no WAIT state or counter is synthesised.

Test Plan:
- Reset: RESET = 1 for 2 cycles with INSTR_VALID = 1, INSTRUCTION = 0x002081B3 -> all outputs 0 throughout; after release, next edge gives ALUOP = 0, REGWR = 1, CTRL_VALID = 1.
- Store: 0x0020A423 (sw x2,8(x1)) -> MEMWR = 1, MUX1 = 1, IMMEDIATE = 001, ALUOP = 0, REGWR = 0. With STALL_IN = 1 for 3 cycles the outputs hold unchanged; the next instruction is accepted one edge after STALL_IN falls.
- Divide (DIV_LATENCY = 4, M_EXT_EN): 0x0220C1B3 (div) -> ALUOP = 14; BUSY = 1 for 3 cycles with the word held. A valid add presented during BUSY is ignored, then accepted the edge after BUSY falls.
- Flush: as the divide test, with FLUSH = 1 in the 2nd BUSY cycle -> next edge all outputs 0, BUSY = 0, CTRL_VALID = 0; the following add is accepted normally.
- Illegal: INSTRUCTION = 0xFFFFFFFF -> ILLEGAL = 1 for one cycle, CTRL_VALID = 0, all flags 0. Without M_EXT_EN, 0x022081B3 (mul) gives the same response.
- Latency 1: MUL_LATENCY = 1, mul followed by add back-to-back -> ALUOP = 10 then 0 on consecutive edges, BUSY never asserted.
